// File: rtl/vga_timing_controller.sv
// vga_timing_controller: free-running VGA raster counters with a pixel/sync realignment output stage.
module vga_timing_controller #(
  parameter int H_VISIBLE     = 800,
  parameter int H_FRONT       = 56,
  parameter int H_SYNC        = 120,
  parameter int H_BACK        = 64,
  parameter int V_VISIBLE     = 600,
  parameter int V_FRONT       = 37,
  parameter int V_SYNC        = 6,
  parameter int V_BACK        = 23,
  parameter bit H_SYNC_POL    = 1'b1,
  parameter bit V_SYNC_POL    = 1'b1,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic        VGA_CLOCK,
  input  logic        RESET,
  input  logic [2:0]  PIXEL,
  output logic [10:0] PIXEL_H,
  output logic [10:0] PIXEL_V,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic        VBLANK_START
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = 3 * PIXEL_LATENCY;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_VISIBLE);
  localparam logic [10:0] V_ACT  = 11'(V_VISIBLE);
  localparam logic [10:0] H_SS   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SS   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048 || PIXEL_LATENCY < 1 || PIXEL_LATENCY > 4) begin : g_bad_cfg
      $error("vga_timing_controller: totals must be <= 2048 and PIXEL_LATENCY in 1..4");
    end
  endgenerate

  logic [10:0] h_q, h_d, v_q, v_d;
  logic [DW-1:0] dl_q, dl_d;
  logic [2:0] raw, del, rgb_q, rgb_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, h_wrap, v_wrap;

  // delay line slots hold {active, hs, vs}; the oldest slot sits in the top bits
  always_comb begin
    h_wrap  = h_q == H_LAST;
    v_wrap  = v_q == V_LAST;
    h_d     = h_wrap ? '0 : h_q + 11'd1;
    v_d     = !h_wrap ? v_q : v_wrap ? '0 : v_q + 11'd1;
    raw     = {h_q < H_ACT && v_q < V_ACT, h_q >= H_SS && h_q < H_SE, v_q >= V_SS && v_q < V_SE};
    dl_d    = DW'({dl_q, raw});
    del     = dl_q[DW-1 -: 3];
    rgb_d   = del[2] ? PIXEL : 3'b000;
    hsync_d = del[1] ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d = del[0] ? V_SYNC_POL : ~V_SYNC_POL;
  end

  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      h_q     <= '0;
      v_q     <= '0;
      dl_q    <= '0;
      rgb_q   <= '0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      dl_q    <= dl_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign PIXEL_H      = h_q;
  assign PIXEL_V      = v_q;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_HSYNC    = hsync_q;
  assign VGA_VSYNC    = vsync_q;
  assign VBLANK_START = h_q == '0 && v_q == V_ACT;
endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller: checks a default-timing and a small latency-3 instance against an arithmetic raster model.
module tb_vga_timing_controller;
  localparam int HV[2]  = '{800, 8};
  localparam int HF[2]  = '{56, 2};
  localparam int HS[2]  = '{120, 2};
  localparam int HB[2]  = '{64, 2};
  localparam int VV[2]  = '{600, 4};
  localparam int VF[2]  = '{37, 1};
  localparam int VS[2]  = '{6, 1};
  localparam int VB[2]  = '{23, 1};
  localparam int LAT[2] = '{1, 3};
  localparam int HIST = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][2:0] pix = '1;
  logic [1:0][10:0] ph, pv;
  logic [1:0] r, g, b, hsy, vsy, vb;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    vga_timing_controller #(
      .H_VISIBLE(HV[i]), .H_FRONT(HF[i]), .H_SYNC(HS[i]), .H_BACK(HB[i]),
      .V_VISIBLE(VV[i]), .V_FRONT(VF[i]), .V_SYNC(VS[i]), .V_BACK(VB[i]),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIXEL_LATENCY(LAT[i])
    ) u_dut (
      .VGA_CLOCK(clk), .RESET(rst), .PIXEL(pix[i]),
      .PIXEL_H(ph[i]), .PIXEL_V(pv[i]),
      .VGA_R(r[i]), .VGA_G(g[i]), .VGA_B(b[i]),
      .VGA_HSYNC(hsy[i]), .VGA_VSYNC(vsy[i]), .VBLANK_START(vb[i])
    );
  end

  int checks = 0, failures = 0;
  int n[2];
  bit mh[2][HIST];
  bit mode = 1'b0, valid = 1'b0;
  bit phs[2], pvs[2];
  int hr1[2], hr2[2], hf1[2], vr1[2], vr2[2], vf1[2], vb1[2], vb2[2];

  function automatic int ht(int i);
    return HV[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vt(int i);
    return VV[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // what the engine produces for raster index k: f(h,v) or solid white
  function automatic int engine(int i, int k);
    int h, v;
    h = k % ht(i);
    v = (k / ht(i)) % vt(i);
    return mh[i][k] ? 7 : ((h ^ v) & 7);
  endfunction

  function automatic int exp_rgb(int i, int k);
    int h, v;
    if (k < 0) return 0;
    h = k % ht(i);
    v = (k / ht(i)) % vt(i);
    return (h < HV[i] && v < VV[i]) ? engine(i, k) : 0;
  endfunction

  function automatic int exp_hs(int i, int k);
    int h;
    if (k < 0) return 0;
    h = k % ht(i);
    return int'(h >= HV[i] + HF[i] && h < HV[i] + HF[i] + HS[i]);
  endfunction

  function automatic int exp_vs(int i, int k);
    int v;
    if (k < 0) return 0;
    v = (k / ht(i)) % vt(i);
    return int'(v >= VV[i] + VF[i] && v < VV[i] + VF[i] + VS[i]);
  endfunction

  task automatic chk(string nm, int i, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] n=%0d got=%0d want=%0d", nm, i, n[i], act, exp);
    end
  endtask

  task automatic clear_marks();
    for (int i = 0; i < 2; i++) begin
      hr1[i] = -1; hr2[i] = -1; hf1[i] = -1; vr1[i] = -1;
      vr2[i] = -1; vf1[i] = -1; vb1[i] = -1; vb2[i] = -1;
      phs[i] = 1'b0; pvs[i] = 1'b0;
    end
  endtask

  task automatic tick();
    int h, v, m;
    @(posedge clk);
    if (rst) valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n[i] = rst ? 0 : n[i] + 1;
      if (n[i] >= HIST) $fatal(1, "FAIL history n=%0d exceeds %0d", n[i], HIST);
      mh[i][n[i]] = mode;
    end
    #1;
    for (int i = 0; i < 2; i++)
      pix[i] = (rst || n[i] < LAT[i]) ? 3'd7 : 3'(engine(i, n[i] - LAT[i]));
    @(negedge clk);
    if (!valid) return;
    for (int i = 0; i < 2; i++) begin
      h = n[i] % ht(i);
      v = (n[i] / ht(i)) % vt(i);
      m = n[i] - LAT[i] - 1;
      chk("pixel_h", i, int'(ph[i]), h);
      chk("pixel_v", i, int'(pv[i]), v);
      chk("vblank_start", i, int'(vb[i]), int'(h == 0 && v == VV[i]));
      chk("rgb", i, int'({r[i], g[i], b[i]}), exp_rgb(i, m));
      chk("hsync", i, int'(hsy[i]), exp_hs(i, m));
      chk("vsync", i, int'(vsy[i]), exp_vs(i, m));
      if (hsy[i] && !phs[i]) begin
        if (hr1[i] < 0) hr1[i] = n[i]; else if (hr2[i] < 0) hr2[i] = n[i];
      end
      if (!hsy[i] && phs[i] && hf1[i] < 0) hf1[i] = n[i];
      if (vsy[i] && !pvs[i]) begin
        if (vr1[i] < 0) vr1[i] = n[i]; else if (vr2[i] < 0) vr2[i] = n[i];
      end
      if (!vsy[i] && pvs[i] && vf1[i] < 0) vf1[i] = n[i];
      if (vb[i]) begin
        if (vb1[i] < 0) vb1[i] = n[i]; else if (vb2[i] < 0) vb2[i] = n[i];
      end
      phs[i] = hsy[i];
      pvs[i] = vsy[i];
    end
  endtask

  initial begin
    n[0] = 0;
    n[1] = 0;
    clear_marks();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // small raster is mid-frame at h=5,v=2 after 33 clocks
    repeat (33) tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_h", i, int'(ph[i]), 0);
      chk("rst_v", i, int'(pv[i]), 0);
      chk("rst_rgb", i, int'({r[i], g[i], b[i]}), 0);
      chk("rst_hsync", i, int'(hsy[i]), 0);
      chk("rst_vsync", i, int'(vsy[i]), 0);
    end
    clear_marks();
    rst = 1'b0;
    tick();
    chk("run_h1", 1, int'(ph[1]), 1);
    tick();
    chk("run_h2", 1, int'(ph[1]), 2);
    repeat (1600) tick();
    mode = 1'b1;
    repeat (1600) tick();
    chk("hs_rise1", 0, hr1[0], 858);
    chk("hs_fall1", 0, hf1[0], 978);
    chk("hs_rise2", 0, hr2[0], 1898);
    chk("hs_rise1", 1, hr1[1], 14);
    chk("hs_fall1", 1, hf1[1], 16);
    chk("hs_rise2", 1, hr2[1], 28);
    chk("vs_rise1", 1, vr1[1], 74);
    chk("vs_fall1", 1, vf1[1], 88);
    chk("vs_rise2", 1, vr2[1], 172);
    chk("vblank1", 1, vb1[1], 56);
    chk("vblank2", 1, vb2[1], 154);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
